// File: rtl/rm_led_monitor_pkg.sv
// Shared types and helpers for the rotating-LED bus monitor: direction codes, FSM states,
// step classification and 4-bit one-hot/rotate helpers.
package rm_led_monitor_pkg;

  localparam logic [1:0] DIR_UNKNOWN = 2'b00;
  localparam logic [1:0] DIR_LEFT    = 2'b01;
  localparam logic [1:0] DIR_RIGHT   = 2'b10;
  localparam logic [1:0] DIR_STALL   = 2'b11;

  typedef enum logic [1:0] {
    StSync,
    StTrack,
    StDecoupled,
    StSettleWait
  } state_e;

  typedef struct packed {
    logic pattern_err;
    logic left;
    logic right;
    logic stall;
    logic seq_err;
  } step_class_t;

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] rotr4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/rm_led_monitor_if.sv
// LED bus between the board-side controller (master) and the monitor (slave).
interface rm_led_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             decouple;
  logic             clr;
  logic [3:0]       led_in;
  logic [3:0]       led_out;
  logic [1:0]       dir;
  logic             locked;
  logic [CNT_W-1:0] step_cnt;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, decouple, clr, led_in,
    input  led_out, dir, locked, step_cnt, err, err_cnt
  );

  modport slave (
    input  en, decouple, clr, led_in,
    output led_out, dir, locked, step_cnt, err, err_cnt
  );
endinterface

// File: rtl/rm_led_monitor_step_decode.sv
// Classifies a new LED sample against the previous valid one.
module rm_led_monitor_step_decode
  import rm_led_monitor_pkg::*;
(
  input  logic [3:0]  prev_i,
  input  logic [3:0]  sample_i,
  output step_class_t cls_o
);

  always_comb begin
    cls_o = '0;
    if (!is_onehot4(sample_i)) begin
      cls_o.pattern_err = 1'b1;
    end else if (sample_i == rotl4(prev_i)) begin
      cls_o.left = 1'b1;
    end else if (sample_i == rotr4(prev_i)) begin
      cls_o.right = 1'b1;
    end else if (sample_i == prev_i) begin
      cls_o.stall = 1'b1;
    end else begin
      cls_o.seq_err = 1'b1;
    end
  end

endmodule

// File: rtl/rm_led_monitor.sv
// Static-region monitor for the reconfigurable partition's rotating one-hot LED bus:
// tracks direction, counts steps and errors, and masks reconfiguration windows.
module rm_led_monitor
  import rm_led_monitor_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  rm_led_monitor_if.slave  bus_io
);

  state_e           state_q, state_d;
  logic             en_q;
  logic [1:0]       dir_q, dir_d;
  logic [3:0]       led_q, led_d;
  logic [3:0]       prev_q, prev_d;
  logic [7:0]       settle_q, settle_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic             err_q, err_d;
  logic             step_inc, err_ev;
  step_class_t      cls;

  rm_led_monitor_step_decode u_decode (
    .prev_i   (prev_q),
    .sample_i (bus_io.led_in),
    .cls_o    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StSync;
      en_q     <= 1'b0;
      dir_q    <= DIR_UNKNOWN;
      led_q    <= 4'd0;
      prev_q   <= 4'd0;
      settle_q <= 8'd0;
      step_q   <= '0;
      errc_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= bus_io.en;
      dir_q    <= dir_d;
      led_q    <= led_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
      step_q   <= step_d;
      errc_q   <= errc_d;
      err_q    <= err_d;
    end
  end

  // decouple wins over any same-cycle sample; en_q marks the post-step sample point.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    led_d    = led_q;
    prev_d   = prev_q;
    settle_d = settle_q;
    step_inc = 1'b0;
    err_ev   = 1'b0;
    if (bus_io.decouple) begin
      state_d = StDecoupled;
    end else begin
      unique case (state_q)
        StSync: begin
          if (en_q) begin
            if (cls.pattern_err) begin
              err_ev = 1'b1;
            end else begin
              prev_d  = bus_io.led_in;
              led_d   = bus_io.led_in;
              state_d = StTrack;
            end
          end
        end
        StTrack: begin
          if (en_q) begin
            if (cls.pattern_err || cls.seq_err ||
                (cls.left && dir_q == DIR_RIGHT) || (cls.right && dir_q == DIR_LEFT)) begin
              err_ev  = 1'b1;
              state_d = StSync;
            end else if (cls.left || cls.right) begin
              dir_d    = cls.left ? DIR_LEFT : DIR_RIGHT;
              prev_d   = bus_io.led_in;
              led_d    = bus_io.led_in;
              step_inc = 1'b1;
            end else if (cls.stall && dir_q == DIR_UNKNOWN) begin
              dir_d = DIR_STALL;
            end
          end
        end
        StDecoupled: begin
          settle_d = 8'(SETTLE);
          state_d  = StSettleWait;
        end
        StSettleWait: begin
          settle_d = settle_q - 8'd1;
          // Forget direction so the next loaded module may rotate either way.
          if (settle_q <= 8'd1) begin
            settle_d = 8'd0;
            dir_d    = DIR_UNKNOWN;
            state_d  = StSync;
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  always_comb begin
    step_d = step_q;
    errc_d = errc_q;
    err_d  = err_q | err_ev;
    if (step_inc && step_q != '1) step_d = step_q + 1'b1;
    if (err_ev && errc_q != '1) errc_d = errc_q + 1'b1;
    if (bus_io.clr) begin
      step_d = '0;
      errc_d = '0;
      err_d  = 1'b0;
    end
  end

  always_comb begin
    bus_io.led_out  = led_q;
    bus_io.dir      = dir_q;
    bus_io.locked   = (state_q == StTrack);
    bus_io.step_cnt = step_q;
    bus_io.err      = err_q;
    bus_io.err_cnt  = errc_q;
  end

endmodule

// File: tb/tb_rm_led_monitor.sv
// Self-checking bench for rm_led_monitor: expected outputs are queued as each step is driven
// and popped once the monitor has sampled it.
module tb_rm_led_monitor;

  typedef struct packed {
    logic [3:0]  led;
    logic [1:0]  dir;
    logic        locked;
    logic [15:0] step;
    logic        err;
    logic [15:0] errc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst2 = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  rm_led_monitor_if #(.CNT_W(16)) bus ();
  rm_led_monitor_if #(.CNT_W(2))  bus2 ();

  rm_led_monitor #(.CNT_W(16), .SETTLE(4)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  rm_led_monitor #(.CNT_W(2), .SETTLE(4)) u_dut2 (
    .clk    (clk),
    .reset  (rst2),
    .bus_io (bus2.slave)
  );

  function automatic obs_t mk(logic [3:0] l, logic [1:0] d, logic lk, int s, logic e, int ec);
    obs_t r;
    r.led = l; r.dir = d; r.locked = lk; r.step = 16'(s); r.err = e; r.errc = 16'(ec);
    return r;
  endfunction

  function automatic obs_t observe();
    return {bus.led_out, bus.dir, bus.locked, bus.step_cnt, bus.err, bus.err_cnt};
  endfunction

  function automatic obs_t observe2();
    return {bus2.led_out, bus2.dir, bus2.locked, 14'd0, bus2.step_cnt, bus2.err, 14'd0,
            bus2.err_cnt};
  endfunction

  // en high for one cycle; the partition's post-step value appears after that edge.
  task automatic drive_step(input logic [3:0] s, input logic c);
    @(negedge clk); bus.en = 1'b1;
    @(negedge clk); bus.en = 1'b0; bus.led_in = s; bus.clr = c;
    @(negedge clk); bus.clr = 1'b0;
  endtask

  task automatic drive_step2(input logic [3:0] s);
    @(negedge clk); bus2.en = 1'b1;
    @(negedge clk); bus2.en = 1'b0; bus2.led_in = s;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; bus.en = 1'b0; bus.clr = 1'b0; bus.decouple = 1'b0; bus.led_in = 4'b0001;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    @(negedge clk);
    reset = 1'b1; bus.en = 1'b0; bus.clr = 1'b0; bus.decouple = 1'b0; bus.led_in = 4'b0001;
    #1;
    exp_q.push_back(mk(4'b0000, 2'b00, 1'b0, 0, 1'b0, 0));
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin
      n_bad++; $display("FAIL reset: got %h want %h", got, e);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_left_rotation();
    logic [3:0] ss [5];
    obs_t ee [5];
    obs_t got, e;
    ss = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ee = '{mk(4'b0010, 2'b00, 1, 0, 0, 0), mk(4'b0100, 2'b01, 1, 1, 0, 0),
           mk(4'b1000, 2'b01, 1, 2, 0, 0), mk(4'b0001, 2'b01, 1, 3, 0, 0),
           mk(4'b0010, 2'b01, 1, 4, 0, 0)};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ee[i]);
      drive_step(ss[i], 1'b0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL left_rot[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_right_rotation();
    logic [3:0] ss [3];
    obs_t ee [3];
    obs_t got, e;
    ss = '{4'b1000, 4'b0100, 4'b0010};
    ee = '{mk(4'b1000, 2'b00, 1, 0, 0, 0), mk(4'b0100, 2'b10, 1, 1, 0, 0),
           mk(4'b0010, 2'b10, 1, 2, 0, 0)};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ee[i]);
      drive_step(ss[i], 1'b0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL right_rot[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_injection();
    logic [3:0] ss [8];
    logic       cc [8];
    obs_t ee [8];
    obs_t got, e;
    ss = '{4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    cc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ee = '{mk(4'b0001, 2'b00, 1, 0, 0, 0), mk(4'b0010, 2'b01, 1, 0, 0, 0),
           mk(4'b0010, 2'b01, 0, 0, 1, 1), mk(4'b0100, 2'b01, 1, 0, 1, 1),
           mk(4'b1000, 2'b01, 1, 1, 1, 1), mk(4'b0001, 2'b01, 1, 2, 1, 1),
           mk(4'b0010, 2'b01, 1, 3, 1, 1), mk(4'b0010, 2'b01, 0, 3, 1, 2)};
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ee[i]);
      drive_step(ss[i], cc[i]);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL inject[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_decouple();
    logic [3:0] ss [4];
    obs_t ee [4];
    obs_t got, e;
    ss = '{4'b0001, 4'b0010, 4'b0100, 4'b0010};
    ee = '{mk(4'b0001, 2'b00, 1, 0, 0, 0), mk(4'b0010, 2'b01, 1, 1, 0, 0),
           mk(4'b0100, 2'b00, 1, 1, 0, 0), mk(4'b0010, 2'b10, 1, 2, 0, 0)};
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ee[i]);
      drive_step(ss[i], 1'b0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL decouple_pre[%0d]: got %h want %h", i, got, e);
      end
    end
    @(negedge clk); bus.decouple = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.led_in = 4'(i * 5 + 3);
      bus.en = (i % 3 == 0);
      n_cmp++;
      if ({bus.locked, bus.err, bus.err_cnt} !== 18'd0) begin
        n_bad++;
        $display("FAIL decoupled[%0d]: got locked=%b err=%b err_cnt=%0d want 0/0/0", i,
                 bus.locked, bus.err, bus.err_cnt);
      end
    end
    // Garbage samples inside the settle window must be ignored.
    @(negedge clk); bus.decouple = 1'b0; bus.en = 1'b1; bus.led_in = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.en = (i == 1);
      n_cmp++;
      if ({bus.locked, bus.err, bus.err_cnt} !== 18'd0) begin
        n_bad++;
        $display("FAIL settle[%0d]: got locked=%b err=%b err_cnt=%0d want 0/0/0", i,
                 bus.locked, bus.err, bus.err_cnt);
      end
    end
    repeat (6) @(negedge clk);
    exp_q.push_back(mk(4'b0010, 2'b00, 0, 1, 0, 0));
    got = observe(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin
      n_bad++; $display("FAIL post_settle: got %h want %h", got, e);
    end
    for (int i = 2; i < 4; i++) begin
      exp_q.push_back(ee[i]);
      drive_step(ss[i], 1'b0);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL decouple_post[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_stall_clr();
    logic [3:0] ss [6];
    logic       cc [6];
    obs_t ee [6];
    obs_t got, e;
    ss = '{4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    cc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ee = '{mk(4'b0000, 2'b00, 0, 0, 1, 1), mk(4'b0100, 2'b00, 1, 0, 1, 1),
           mk(4'b0100, 2'b11, 1, 0, 1, 1), mk(4'b0100, 2'b11, 1, 0, 1, 1),
           mk(4'b1000, 2'b01, 1, 1, 1, 1), mk(4'b0001, 2'b01, 1, 0, 0, 0)};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ee[i]);
      drive_step(ss[i], cc[i]);
      got = observe(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL stall_clr[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] ss [7];
    obs_t got, e;
    ss = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mk(ss[i], (i == 0) ? 2'b00 : 2'b01, 1, (i > 3) ? 3 : i, 0, 0));
      drive_step2(ss[i]);
      got = observe2(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL saturate[%0d]: got %h want %h", i, got, e);
      end
    end
    // Asynchronous reset between clock edges must clear outputs at once.
    @(negedge clk); bus2.en = 1'b1;
    #2 rst2 = 1'b1;
    #1;
    exp_q.push_back(mk(4'b0000, 2'b00, 0, 0, 0, 0));
    got = observe2(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin
      n_bad++; $display("FAIL async_reset: got %h want %h", got, e);
    end
    @(negedge clk); bus2.en = 1'b0; rst2 = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.decouple = 1'b0; bus.led_in = 4'b0001;
    bus2.en = 1'b0; bus2.clr = 1'b0; bus2.decouple = 1'b0; bus2.led_in = 4'b0001;
    test_reset();
    test_left_rotation();
    test_right_rotation();
    test_injection();
    test_decouple();
    test_stall_clr();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
